count_request_scheduler: RTL

//  Arbitrates and sequences operations on the shared two-digit BCD display counter.

---
 rtl/count_request_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/count_request_scheduler.sv
// Request scheduler for the shared two-digit BCD counter: edge-detects up/down/clear,
// latches pending requests and grants one per APPLY slot with a programmable cool-down.
module count_request_scheduler #(
    parameter int unsigned MAX_COUNT  = 99,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iUp,
    input  logic       iDown,
    input  logic       iClr,
    output logic [3:0] oUnidades,
    output logic [3:0] oDecenas,
    output logic [2:0] oGrant,
    output logic       oBusy,
    output logic       oWrap,
    output logic       oDrop
);

    localparam int unsigned GAP_W = 8;
    localparam logic [3:0] MAX_T = 4'(MAX_COUNT / 10);
    localparam logic [3:0] MAX_U = 4'(MAX_COUNT % 10);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // Request vectors are ordered {clr, down, up}
    localparam int unsigned B_UP  = 0;
    localparam int unsigned B_DN  = 1;
    localparam int unsigned B_CLR = 2;

    logic [2:0]       btn;
    logic [2:0]       req;
    logic [2:0]       clr_mask;
    logic [2:0]       prev_q;
    logic [2:0]       pend_q, pend_d;
    logic [1:0]       state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             rr_q, rr_d;
    logic [2:0]       grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             wrap_q, wrap_d;
    logic             drop_q, drop_d;
    logic [3:0]       unid_q, unid_d;
    logic [3:0]       dec_q, dec_d;

    assign btn = {iClr, iDown, iUp};
    assign req = btn & ~prev_q;

    // Next-state: arbitration, slot sequencing and BCD arithmetic
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        rr_d     = rr_q;
        grant_d  = 3'b000;
        clr_mask = 3'b000;
        unid_d   = unid_q;
        dec_d    = dec_q;
        wrap_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    state_d = S_APPLY;
                    if (pend_q[B_CLR]) begin
                        grant_d  = 3'b100;
                        clr_mask = 3'b111;
                    end else if (pend_q[B_UP] && pend_q[B_DN]) begin
                        grant_d = rr_q ? 3'b010 : 3'b001;
                    end else if (pend_q[B_UP]) begin
                        grant_d = 3'b001;
                    end else begin
                        grant_d = 3'b010;
                    end
                    clr_mask = clr_mask | grant_d;
                    if (grant_d[B_UP]) rr_d = 1'b1;
                    if (grant_d[B_DN]) rr_d = 1'b0;
                end
            end
            S_APPLY: begin
                if (grant_q[B_CLR]) begin
                    unid_d = 4'd0;
                    dec_d  = 4'd0;
                end else if (grant_q[B_UP]) begin
                    if (dec_q == MAX_T && unid_q == MAX_U) begin
                        unid_d = 4'd0;
                        dec_d  = 4'd0;
                        wrap_d = 1'b1;
                    end else if (unid_q == 4'd9) begin
                        unid_d = 4'd0;
                        dec_d  = dec_q + 4'd1;
                    end else begin
                        unid_d = unid_q + 4'd1;
                    end
                end else if (grant_q[B_DN]) begin
                    if (dec_q == 4'd0 && unid_q == 4'd0) begin
                        unid_d = MAX_U;
                        dec_d  = MAX_T;
                        wrap_d = 1'b1;
                    end else if (unid_q == 4'd0) begin
                        unid_d = 4'd9;
                        dec_d  = dec_q - 4'd1;
                    end else begin
                        unid_d = unid_q - 4'd1;
                    end
                end
                gap_d   = GAP_LOAD;
                state_d = (GAP_LOAD != '0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new edge always wins over a grant clearing the same flag
        pend_d = (pend_q & ~clr_mask) | req;
        drop_d = |(req & pend_q);
        busy_d = (state_d != S_IDLE);
    end

    // History regs reset high so a level held through reset is not a request
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            prev_q  <= 3'b111;
            pend_q  <= 3'b000;
            state_q <= S_IDLE;
            gap_q   <= '0;
            rr_q    <= 1'b0;
            grant_q <= 3'b000;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            drop_q  <= 1'b0;
            unid_q  <= 4'd0;
            dec_q   <= 4'd0;
        end else begin
            prev_q  <= btn;
            pend_q  <= pend_d;
            state_q <= state_d;
            gap_q   <= gap_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            drop_q  <= drop_d;
            unid_q  <= unid_d;
            dec_q   <= dec_d;
        end
    end

    assign oUnidades = unid_q;
    assign oDecenas  = dec_q;
    assign oGrant    = grant_q;
    assign oBusy     = busy_q;
    assign oWrap     = wrap_q;
    assign oDrop     = drop_q;

endmodule
